// File: rtl/seq_alu.sv
// seq_alu -- execute-stage ALU with registered result and NZCV flags.
//
// Single-cycle ops (AND/OR/ADD/SUB/PASSB/LSL/LSR/ASR) complete on the
// accepting edge. MUL runs an iterative shift-add multiply for WIDTH edges.
// Valid/ready handshakes on both sides let the controller stall on MUL.
//
// Ports:
//   CLK        clock, rising edge
//   Reset      synchronous active-high reset
//   BusA/BusB  operands (BusB is also shift amount / multiplier)
//   ALUCtrl    operation select
//   in_valid   operands valid     / in_ready  operands accepted this cycle
//   BusW       registered result  / Zero, Negative, Carry, Overflow flags
//   out_valid  result present     / out_ready consumer takes result
module seq_alu #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;   // cnt must hold the value WIDTH itself

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_LSL   = 4'd3;
  localparam logic [3:0] OP_LSR   = 4'd4;
  localparam logic [3:0] OP_ASR   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_PASSB = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] busw_q, busw_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Single-cycle datapath
  logic [WIDTH:0]   sum_w, diff_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;
  logic             accept;
  logic [WIDTH-1:0] acc_sum;

  assign in_ready = !Reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign BusW      = busw_q;
  assign Zero      = z_q;
  assign Negative  = n_q;
  assign Carry     = c_q;
  assign Overflow  = v_q;
  assign out_valid = out_valid_q;

  always_comb begin
    sum_w  = {1'b0, BusA} + {1'b0, BusB};
    diff_w = {1'b0, BusA} - {1'b0, BusB};
    shamt  = BusB[SHW-1:0];
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (ALUCtrl)
      OP_AND:   sc_res = BusA & BusB;
      OP_OR:    sc_res = BusA | BusB;
      OP_ADD: begin
        sc_res = sum_w[WIDTH-1:0];
        sc_c   = sum_w[WIDTH];
        sc_v   = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (sum_w[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff_w[WIDTH-1:0];
        // Borrow out of the extended subtraction means A < B unsigned.
        sc_c   = !diff_w[WIDTH];
        sc_v   = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (diff_w[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_PASSB: sc_res = BusB;
      OP_LSL:   sc_res = BusA << shamt;
      OP_LSR:   sc_res = BusA >> shamt;
      OP_ASR:   sc_res = WIDTH'($signed(BusA) >>> shamt);
      default:  sc_res = '0;
    endcase
  end

  // One shift-add iteration of the multiplier
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    busw_d      = busw_q;
    z_d         = z_q;
    n_d         = n_q;
    c_d         = c_q;
    v_d         = v_q;
    out_valid_d = out_valid_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (ALUCtrl == OP_MUL) begin
            mcand_d     = BusA;
            mplier_d    = BusB;
            acc_d       = '0;
            cnt_d       = CW'(WIDTH);
            state_d     = S_MUL;
            out_valid_d = 1'b0;
          end else begin
            busw_d      = sc_res;
            z_d         = (sc_res == '0);
            n_d         = sc_res[WIDTH-1];
            c_d         = sc_c;
            v_d         = sc_v;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busw_d      = acc_sum;
          z_d         = (acc_sum == '0);
          n_d         = acc_sum[WIDTH-1];
          c_d         = 1'b0;
          v_d         = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      busw_q      <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      busw_q      <= busw_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu -- directed-vector scoreboard bench for seq_alu (WIDTH=64).
// Stimulus pushes the hand-computed result and NZCV flags into a queue when
// an operation is accepted; a monitor pops and compares on each output
// transfer (out_valid && out_ready).
module tb_seq_alu;
  localparam int W = 64;

  logic         CLK = 1'b0;
  logic         Reset;
  logic [W-1:0] BusA, BusB;
  logic [3:0]   ALUCtrl;
  logic         in_valid, in_ready;
  logic [W-1:0] BusW;
  logic         Zero, Negative, Carry, Overflow;
  logic         out_valid, out_ready;

  seq_alu #(.WIDTH(W)) dut (
    .CLK(CLK), .Reset(Reset), .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl),
    .in_valid(in_valid), .in_ready(in_ready), .BusW(BusW),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] w;
    logic [3:0]   nzcv;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
  endtask

  // Monitor: compare on every output transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out: got 0x%016h expected no output", BusW);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_w"}, BusW, e.w);
          check({e.name, "_nzcv"}, {60'd0, Negative, Zero, Carry, Overflow}, {60'd0, e.nzcv});
          $display("out %s BusW=0x%016h NZCV=%b", e.name, BusW, {Negative, Zero, Carry, Overflow});
        end
      end
    end
  end

  // Drive one operation, wait for acceptance, push expectation, return #1 after the accepting edge.
  task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ew, input logic [3:0] ef,
                       input bit push);
    exp_t e;
    bit ok = 0;
    ALUCtrl = op; BusA = a; BusB = b; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (in_ready === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      $display("FAIL %s_accept: got in_ready=0 expected acceptance within 200 cycles", name);
    end else begin
      if (push) begin
        e.w = ew; e.nzcv = ef; e.name = name;
        exp_q.push_back(e);
      end
      $display("in  %s op=%0d A=0x%016h B=0x%016h", name, op, a, b);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int  n;
    bit  seen;
    logic [W-1:0] hold_w;
    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    BusA = '0; BusB = '0; ALUCtrl = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busw", BusW, 64'd0);
    check("rst_flags", {60'd0, Negative, Zero, Carry, Overflow}, 64'd0);
    Reset = 1'b0;
    #1;
    check("rst_release_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge CLK); #1;

    // ADD signed overflow, latency 0 after accept
    issue("add_ovf", 4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001, 1);
    check("add_latency_valid", {63'd0, out_valid}, 64'd1);
    issue("add_carry", 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110, 1);
    issue("sub_eq", 4'd6, 64'd5, 64'd5, 64'd0, 4'b0110, 1);
    issue("sub_borrow", 4'd6, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1);
    issue("sub_ovf", 4'd6, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1);
    issue("lsr", 4'd4, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 4'b0000, 1);
    issue("asr", 4'd5, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 4'b1000, 1);
    issue("lsl_wrap", 4'd3, 64'd1, 64'd68, 64'h10, 4'b0000, 1);
    issue("passb", 4'd7, 64'h1234, 64'd0, 64'd0, 4'b0100, 1);
    issue("undef9", 4'd9, 64'h55, 64'h77, 64'd0, 4'b0100, 1);

    // MUL latency and in_ready blocking
    issue("mul_a", 4'd8, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003, 4'b0000, 1);
    n = 0; seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid === 1'b1) begin seen = 1; break; end
      if (in_ready !== 1'b0) seen = 0;
      check("mul_in_ready_low", {63'd0, in_ready}, 64'd0);
      @(posedge CLK); #1;
      n++;
    end
    check("mul_latency", 64'(n), 64'd64);
    issue("mul_ones", 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 1);
    for (int i = 0; i < 200 && out_valid !== 1'b1; i++) begin @(posedge CLK); #1; end
    @(posedge CLK); #1;

    // Backpressure: AND held while out_ready low
    out_ready = 1'b0;
    issue("and_hold", 4'd0, 64'h00FF_00FF_F0F0_0000, 64'h0F0F_FFFF_FF00_1234,
          64'h000F_00FF_F000_0000, 4'b0000, 1);
    hold_w = 64'h000F_00FF_F000_0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check("hold_busw", BusW, hold_w);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    issue("or_b2b", 4'd1, 64'h8000_0000_0000_0001, 64'd2, 64'h8000_0000_0000_0003, 4'b1000, 1);
    check("b2b_valid", {63'd0, out_valid}, 64'd1);
    check("b2b_busw", BusW, 64'h8000_0000_0000_0003);

    // Stream 8 ADDs with out_ready high
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      ALUCtrl = 4'd2; BusA = 64'(i); BusB = 64'd100; in_valid = 1'b1;
      @(negedge CLK);
      check("stream_in_ready", {63'd0, in_ready}, 64'd1);
      e.w = 64'(i + 100); e.nzcv = 4'b0000; e.name = "stream_add";
      exp_q.push_back(e);
      $display("in  stream_add A=%0d B=100", i);
      @(posedge CLK); #1;
      check("stream_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    @(posedge CLK); #1;

    // Reset mid-MUL at iteration 10
    issue("mul_abort", 4'd8, 64'd5, 64'd7, 64'd35, 4'b0000, 0);
    repeat (9) @(posedge CLK);
    #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    check("abort_valid", {63'd0, out_valid}, 64'd0);
    check("abort_busw", BusW, 64'd0);
    check("abort_flags", {60'd0, Negative, Zero, Carry, Overflow}, 64'd0);
    check("abort_in_ready_rst", {63'd0, in_ready}, 64'd0);
    Reset = 1'b0;
    #1;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge CLK); #1;
      if (out_valid === 1'b1) seen = 1;
    end
    check("abort_no_stale", {63'd0, seen}, 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the single-cycle execute ALU. It registers its result and a full NZCV flag set. It adds shift operations and an iterative shift-add multiplier, and keeps the existing ALUCtrl encodings for AND/OR/ADD/SUB/PASSB. It sits in the execute stage of the multi-cycle datapath, between the register-read latches and the writeback/branch logic, and uses valid/ready on both sides so the controller can stall on multiplies.

## Interface
- WIDTH, 64, operand/result width; power of two, 8..128.
- SHW, $clog2(WIDTH), derived (localparam): shift-amount bits taken from BusB.
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- BusA  input  WIDTH  operand A.
- BusB  input  WIDTH  operand B / shift amount / multiplier.
- ALUCtrl  input  4  operation select.
- in_valid  input  1  operands and ALUCtrl valid.
- in_ready  output  1  block accepts operands this cycle.
- BusW  output  WIDTH  registered result.
- Zero, Negative, Carry, Overflow  output  1 each  registered flags for BusW.
- out_valid  output  1  BusW and flags hold a result.
- out_ready  input  1  consumer takes the result this cycle.

## Operation
- ALUCtrl encoding:
  - 0 AND; 1 OR; 2 ADD; 6 SUB (A-B); 7 PASSB.
  - 3 LSL: A << B[SHW-1:0]. 4 LSR: A >> B[SHW-1:0], logical. 5 ASR: A >>> B[SHW-1:0], arithmetic.
  - 8 MUL: low WIDTH bits of A*B. The result is the same for signed and unsigned operands.
  - All other codes: BusW = 0, single-cycle.
- Flags are computed from the new result and registered with it.
  - Zero = (BusW == 0). Negative = BusW[WIDTH-1].
  - Carry: ADD gives the carry-out of bit WIDTH-1. SUB gives 1 when A >= B unsigned (no borrow). All other ops give 0.
  - Overflow: signed overflow for ADD/SUB. All other ops give 0.
- States:
  - IDLE: single-cycle ops complete here.
  - MUL: iterative multiply in progress.
- Acceptance: a transfer occurs when in_valid && in_ready. in_ready = !Reset && state==IDLE && (!out_valid || out_ready).
- Single-cycle op accepted: result and flags are loaded on that edge and out_valid is set. State stays IDLE.
- MUL accepted: latch the multiplicand (A), the multiplier (B), acc = 0 and cnt = WIDTH. The state goes to MUL and out_valid is cleared.
- Each edge in MUL performs one iteration:
  - if multiplier[0], acc += multiplicand (mod 2^WIDTH);
  - multiplicand <<= 1; multiplier >>= 1; cnt -= 1.
  - On the iteration where cnt goes 1 -> 0: write the final acc to BusW, set the flags, set out_valid, return to IDLE.
- Output handshake:
  - out_valid && out_ready with no new acceptance: out_valid clears; BusW and the flags keep their value.
  - out_valid && !out_ready: BusW, the flags and out_valid stay stable.
- Simultaneous output consume and input accept: the new single-cycle result replaces the old one on the same edge, giving back-to-back throughput of 1 per cycle. For MUL, out_valid drops.
- ALUCtrl, BusA and BusB are ignored while in MUL or when in_valid is low.

## Timing
- Reset (synchronous, any state, including mid-MUL) on the next edge:
  - state = IDLE, out_valid = 0, BusW = 0;
  - Zero = Negative = Carry = Overflow = 0;
  - the multiplier registers and cnt are cleared, and any partial product is discarded.
- in_ready is 0 while Reset is high and 1 on the first cycle after Reset deasserts.
- Latency is measured from the accepting edge k:
  - Single-cycle ops: out_valid is high from edge k.
  - MUL: out_valid is high from edge k+WIDTH, i.e. WIDTH edges in the MUL state. in_ready is 0 for cycles k+1 .. k+WIDTH.
- Throughput: 1 op/cycle for single-cycle ops with out_ready held high. MUL issues at most one per WIDTH+1 cycles.
- No combinational path from BusA, BusB or ALUCtrl to any output. in_ready depends combinationally on out_ready.

## Test plan
- ADD, WIDTH=64: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> on the edge after acceptance, BusW=0x8000_0000_0000_0000, N=1, V=1, C=0, Z=0, out_valid=1.
- SUB: A=B=5 -> BusW=0, Z=1, C=1, V=0. SUB A=0, B=1 -> BusW=all-ones, N=1, C=0.
- Shifts: A=0x8000_0000_0000_0000, B=4 -> LSR gives 0x0800_0000_0000_0000, ASR gives 0xF800_0000_0000_0000. With B=68, LSL of A=1 gives 0x10, since only the low 6 bits of B are used.
- MUL: A=0x1_0000_0001, B=3 -> BusW=0x3_0000_0003, out_valid rising exactly 64 edges after acceptance, in_ready=0 throughout. A=B=all-ones -> BusW=1.
- Backpressure:
  - Hold out_ready=0 after an AND result: BusW and flags stay stable and in_ready=0.
  - Raise out_ready with in_valid (OR) in the same cycle: the next result appears on the following edge with no bubble.
  - Stream 8 ADDs with out_ready=1: 8 results on 8 consecutive edges.
- Reset mid-MUL at iteration 10 -> next edge out_valid=0, BusW=0, all flags 0. in_ready=1 after Reset drops, and no stale MUL result ever appears.
